delay_line_var: RTL and testbench

- Parametrised, runtime-selectable multi-stage delay line for N-bit data, with per-stage valid tracking, clock enable (stall) and synchronous flush.
- Generalises the fixed three-stage register chain: configurable width and maximum depth, tap selection at run time, and exposure of all intermediate stages.
- Sits between producers and consumers that need sample alignment (e.g. matching latency of parallel datapaths).

---
 rtl/delay_line_var.sv | 95 +++++++++
 tb/tb_delay_line_var.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_var.sv
// Runtime-selectable delay line: MAX_DEPTH register stages with per-stage valid,
// stall, synchronous flush and a combinational tap mux clamped to 1..MAX_DEPTH.
module delay_line_var #(
    parameter int WIDTH     = 8,
    parameter int MAX_DEPTH = 4,
    localparam int SEL_W    = $clog2(MAX_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           din,
    input  logic [SEL_W-1:0]           delay_sel,
    output logic [WIDTH-1:0]           dout,
    output logic                       out_valid,
    output logic [WIDTH*MAX_DEPTH-1:0] taps,
    output logic [MAX_DEPTH-1:0]       tap_valid,
    output logic [SEL_W-1:0]           occupancy
);

    logic [WIDTH-1:0]     stage_p [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] vld_p;
    logic [MAX_DEPTH-1:0] vld_nxt;
    logic [SEL_W-1:0]     occ_p;
    logic [SEL_W-1:0]     eff_sel;

    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
        if (s == '0)
            return SEL_W'(1);
        if (s > SEL_W'(MAX_DEPTH))
            return SEL_W'(MAX_DEPTH);
        return s;
    endfunction

    function automatic logic [SEL_W-1:0] popcount(input logic [MAX_DEPTH-1:0] v);
        logic [SEL_W-1:0] c;
        c = '0;
        for (int k = 0; k < MAX_DEPTH; k++)
            c = c + SEL_W'(v[k]);
        return c;
    endfunction

    always_comb begin
        vld_nxt    = '0;
        vld_nxt[0] = in_valid;
        for (int k = 1; k < MAX_DEPTH; k++)
            vld_nxt[k] = vld_p[k-1];
    end

    // Stage register chain: occupancy is registered alongside so it tracks the new valid vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MAX_DEPTH; k++)
                stage_p[k] <= '0;
            vld_p <= '0;
            occ_p <= '0;
        end else if (flush) begin
            for (int k = 0; k < MAX_DEPTH; k++)
                stage_p[k] <= '0;
            vld_p <= '0;
            occ_p <= '0;
        end else if (en) begin
            stage_p[0] <= din;
            for (int k = 1; k < MAX_DEPTH; k++)
                stage_p[k] <= stage_p[k-1];
            vld_p <= vld_nxt;
            occ_p <= popcount(vld_nxt);
        end
    end

    // Tap selection straight from the registers, so a delay change lands in the same cycle
    assign eff_sel = clamp_sel(delay_sel);

    always_comb begin
        dout      = '0;
        out_valid = 1'b0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (eff_sel == SEL_W'(k + 1)) begin
                dout      = stage_p[k];
                out_valid = vld_p[k];
            end
        end
    end

    always_comb begin
        taps = '0;
        for (int k = 0; k < MAX_DEPTH; k++)
            taps[k*WIDTH +: WIDTH] = stage_p[k];
    end

    assign tap_valid = vld_p;
    assign occupancy = occ_p;

endmodule

// File: tb/tb_delay_line_var.sv
// Directed bench for delay_line_var (default MAX_DEPTH=4 plus a single-stage instance).
module tb_delay_line_var;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        flush;
    logic        in_valid;
    logic [7:0]  din;
    logic [2:0]  delay_sel;
    logic [7:0]  dout;
    logic        out_valid;
    logic [31:0] taps;
    logic [3:0]  tap_valid;
    logic [2:0]  occupancy;

    logic        delay_sel1;
    logic [7:0]  dout1;
    logic        out_valid1;
    logic [7:0]  taps1;
    logic [0:0]  tap_valid1;
    logic [0:0]  occupancy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    delay_line_var #(.WIDTH(8), .MAX_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .din(din), .delay_sel(delay_sel), .dout(dout), .out_valid(out_valid),
        .taps(taps), .tap_valid(tap_valid), .occupancy(occupancy)
    );

    delay_line_var #(.WIDTH(8), .MAX_DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .din(din), .delay_sel(delay_sel1), .dout(dout1), .out_valid(out_valid1),
        .taps(taps1), .tap_valid(tap_valid1), .occupancy(occupancy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        en         = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b1;
        din        = 8'hAA;
        delay_sel  = 3'd1;
        delay_sel1 = 1'b0;

        // Reset held with live input
        repeat (5) tick();
        check("rst_dout", dout, 8'h00);
        check("rst_ov", out_valid, 1'b0);
        check("rst_taps", taps, 32'h0);
        check("rst_tapv", tap_valid, 4'h0);
        check("rst_occ", occupancy, 3'd0);

        reset = 1'b1;
        tick();
        check("rel_taps", taps, 32'h0000_00AA);
        check("rel_dout", dout, 8'hAA);
        check("rel_ov", out_valid, 1'b1);
        check("rel_occ", occupancy, 3'd1);
        check("rel_d1", dout1, 8'hAA);

        do_flush();
        check("fl_occ", occupancy, 3'd0);

        // Fixed delay of 3 over a 5-sample burst
        delay_sel = 3'd3;
        for (int n = 1; n <= 9; n++) begin
            if (n <= 5) begin
                din = 8'(n);
                in_valid = 1'b1;
            end else begin
                din = 8'h00;
                in_valid = 1'b0;
            end
            delay_sel1 = n[0];
            tick();
            check("fix_ov", out_valid, (n >= 3 && n <= 7));
            check("fix_dout", dout, (n >= 3 && n <= 7) ? 8'(n - 2) : 8'h00);
            if (n <= 5) begin
                check("fix_occ", occupancy, (n < 4) ? 3'(n) : 3'd4);
                check("d1_dout", dout1, 8'(n));
                check("d1_ov", out_valid1, 1'b1);
                check("d1_occ", occupancy1, 1'b1);
            end
        end

        do_flush();

        // Stall mid-flight with delay 2
        delay_sel = 3'd2;
        din = 8'h11; in_valid = 1'b1; en = 1'b1;
        tick();
        check("st_taps0", taps, 32'h0000_0011);
        check("st_ov0", out_valid, 1'b0);
        en = 1'b0; din = 8'h99;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("st_taps", taps, 32'h0000_0011);
            check("st_occ", occupancy, 3'd1);
            check("st_ov", out_valid, 1'b0);
        end
        en = 1'b1; din = 8'h22;
        tick();
        check("st_dout", dout, 8'h11);
        check("st_ov5", out_valid, 1'b1);
        check("st_taps5", taps, 32'h0000_1122);
        check("st_occ5", occupancy, 3'd2);
        din = 8'h00; in_valid = 1'b0;
        tick();
        check("st_dout6", dout, 8'h22);
        check("st_ov6", out_valid, 1'b1);

        do_flush();

        // Flush colliding with a valid sample while stalled
        delay_sel = 3'd4;
        in_valid = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            din = 8'hA0 + 8'(n);
            tick();
        end
        check("fc_occ4", occupancy, 3'd4);
        check("fc_taps", taps, 32'hA1A2_A3A4);
        check("fc_dout", dout, 8'hA1);
        flush = 1'b1; en = 1'b0; din = 8'h77; in_valid = 1'b1;
        tick();
        flush = 1'b0; en = 1'b1; din = 8'h00; in_valid = 1'b0;
        check("fc_tapv", tap_valid, 4'h0);
        check("fc_occ", occupancy, 3'd0);
        check("fc_taps0", taps, 32'h0);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("fc_no77", dout, 8'h00);
            check("fc_ov", out_valid, 1'b0);
        end

        // Clamping: 0 acts as 1, 7 acts as 4
        delay_sel = 3'd0;
        din = 8'h5A; in_valid = 1'b1;
        tick();
        check("cl0_dout", dout, 8'h5A);
        check("cl0_ov", out_valid, 1'b1);
        do_flush();
        delay_sel = 3'd7;
        din = 8'h3C; in_valid = 1'b1;
        tick();
        din = 8'h00; in_valid = 1'b0;
        tick();
        tick();
        check("cl7_ov3", out_valid, 1'b0);
        tick();
        check("cl7_dout", dout, 8'h3C);
        check("cl7_ov", out_valid, 1'b1);

        // Mid-stream delay change 4 -> 1 while streaming 10..20
        do_flush();
        delay_sel = 3'd4;
        in_valid = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            din = 8'(10 + i);
            tick();
        end
        check("ms_dout4", dout, 8'd13);
        delay_sel = 3'd1;
        #1;
        check("ms_jump", dout, 8'd16);
        check("ms_ov", out_valid, 1'b1);
        for (int i = 7; i <= 10; i++) begin
            din = 8'(10 + i);
            tick();
            check("ms_dout1", dout, 8'(10 + i));
            check("ms_ov1", out_valid, 1'b1);
        end

        // Bubbles: alternating valid, delay 4
        do_flush();
        delay_sel = 3'd4;
        for (int n = 1; n <= 8; n++) begin
            din = 8'h30 + 8'(n);
            in_valid = n[0];
            tick();
            if (n >= 4) begin
                check("bb_ov", out_valid, (n % 2 == 0));
                check("bb_dout", dout, 8'h30 + 8'(n - 3));
            end
            if (n == 4) begin
                check("bb_tapv", tap_valid, 4'b1010);
                check("bb_taps", taps, 32'h3132_3334);
                check("bb_occ", occupancy, 3'd2);
            end
        end

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        check("ar_taps", taps, 32'h0);
        check("ar_tapv", tap_valid, 4'h0);
        check("ar_occ", occupancy, 3'd0);
        check("ar_dout", dout, 8'h00);
        tick();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
